// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the interrupt arbiter.
// Contents: arbiter state enum, default cause base, grant index width.
package irq_pkg;
    typedef enum logic [1:0] {IDLE, OFFER, SERVICE} irq_state_t;
    localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;
    localparam int IRQ_IDX_W = 4;
endpackage

// File: rtl/irq_rr_picker.sv
// irq_rr_picker: combinational winner selection among effective requests.
// Ports: eff (masked requests), ptr (search start), idx (winner), valid (any request).
// IRQ_ARB_ROUND_ROBIN_EN defined: search upward from ptr with wrap; undefined: lowest index wins.
module irq_rr_picker
    import irq_pkg::*;
#(
    parameter int N_IRQ = 16
) (
    input  logic [N_IRQ-1:0]     eff,
    input  logic [IRQ_IDX_W-1:0] ptr,
    output logic [IRQ_IDX_W-1:0] idx,
    output logic                 valid
);
    localparam logic [IRQ_IDX_W:0] NW = (IRQ_IDX_W+1)'(N_IRQ);
    logic [N_IRQ-1:0]     rot;
    logic [IRQ_IDX_W-1:0] pos;
    logic [IRQ_IDX_W:0]   sum;
    assign valid = |eff;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
    // Rotate so ptr lands on bit 0, priority-encode, then rotate the index back.
    always_comb begin
        rot = N_IRQ'({eff, eff} >> ptr);
        pos = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) pos = rot[i] ? IRQ_IDX_W'(i) : pos;
        sum = {1'b0, pos} + {1'b0, ptr};
        idx = (sum >= NW) ? IRQ_IDX_W'(sum - NW) : IRQ_IDX_W'(sum);
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    always_comb begin
        rot = eff;
        pos = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) pos = rot[i] ? IRQ_IDX_W'(i) : pos;
        sum = {1'b0, pos};
        idx = pos;
    end
`endif
endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: sequences peripheral interrupt lines onto the core's single interrupt input.
// Ports: clk_i/rst (sync, active-high); irq_req_i/irq_mask_i peripheral side;
// irq_o/irq_cause_o/irq_ack_i/irq_ret_i core side; irq_ret_o one-hot return pulse; busy_o.
// IRQ_ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int          N_IRQ      = 16,
    parameter logic [31:0] CAUSE_BASE = IRQ_CAUSE_BASE
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [N_IRQ-1:0] irq_mask_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    input  logic             irq_ack_i,
    input  logic             irq_ret_i,
    output logic [N_IRQ-1:0] irq_ret_o,
    output logic             busy_o
);
    irq_state_t           state, state_n;
    logic [IRQ_IDX_W-1:0] w, w_n, ptr, pick;
    logic [N_IRQ-1:0]     eff, ret_n;
    logic [31:0]          cause_n;
    logic                 irq_n, valid;
    assign eff = irq_req_i & irq_mask_i;
    irq_rr_picker #(.N_IRQ(N_IRQ)) u_picker (
        .eff   (eff),
        .ptr   (ptr),
        .idx   (pick),
        .valid (valid)
    );
`ifdef IRQ_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_i) begin
        if (rst)
            ptr <= '0;
        else if (state == SERVICE && irq_ret_i)
            ptr <= (32'(w) == N_IRQ - 1) ? '0 : w + 1'b1;
    end
`else
    assign ptr = '0;
`endif
    always_comb begin
        state_n = state;
        w_n     = w;
        cause_n = irq_cause_o;
        irq_n   = irq_o;
        ret_n   = '0;
        case (state)
            IDLE: if (valid) begin
                state_n = OFFER;
                w_n     = pick;
                cause_n = CAUSE_BASE + 32'(pick);
                irq_n   = 1'b1;
            end
            // Ack takes precedence over a same-cycle withdrawal.
            OFFER: if (irq_ack_i) begin
                state_n = SERVICE;
                irq_n   = 1'b0;
            end else if (!eff[w]) begin
                state_n = IDLE;
                irq_n   = 1'b0;
            end
            SERVICE: if (irq_ret_i) begin
                state_n = IDLE;
                ret_n   = N_IRQ'(1) << w;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state       <= IDLE;
            w           <= '0;
            irq_o       <= 1'b0;
            irq_cause_o <= '0;
            irq_ret_o   <= '0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_n;
            w           <= w_n;
            irq_o       <= irq_n;
            irq_cause_o <= cause_n;
            irq_ret_o   <= ret_n;
            busy_o      <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: scoreboard bench for irq_arbiter (follows IRQ_ARB_ROUND_ROBIN_EN if defined).
module tb_irq_arbiter;
    localparam int          N  = 16;
    localparam logic [31:0] CB = 32'h8000_0010;
    logic          clk_i = 0, rst = 1, irq_ack_i = 0, irq_ret_i = 0;
    logic [N-1:0]  irq_req_i = '0, irq_mask_i = '1, irq_ret_o;
    logic          irq_o, busy_o;
    logic [31:0]   irq_cause_o;
    int            n_checks = 0, n_fail = 0, mp = 0;
    logic [31:0]   cq[$];
    logic [N-1:0]  rq[$];

    irq_arbiter #(.N_IRQ(N), .CAUSE_BASE(CB)) dut (
        .clk_i       (clk_i),
        .rst         (rst),
        .irq_req_i   (irq_req_i),
        .irq_mask_i  (irq_mask_i),
        .irq_o       (irq_o),
        .irq_cause_o (irq_cause_o),
        .irq_ack_i   (irq_ack_i),
        .irq_ret_i   (irq_ret_i),
        .irq_ret_o   (irq_ret_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Model: first set bit searching upward from mp with wrap.
    task automatic expect_grant(input logic [N-1:0] e);
        int w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && e[(mp + k) % N]) w = (mp + k) % N;
        cq.push_back(CB + 32'(w));
        rq.push_back(N'(1) << w);
`ifdef IRQ_ARB_ROUND_ROBIN_EN
        mp = (w + 1) % N;
`endif
    endtask

    task automatic serve(input logic [N-1:0] next_req);
        int n = 0;
        while (irq_o !== 1'b1 && n < 8) begin tick(); n++; end
        check("irq_up", 32'(irq_o), 1);
        check("cause", irq_cause_o, (cq.size() > 0) ? cq.pop_front() : 32'hdead_beef);
        check("busy_offer", 32'(busy_o), 1);
        irq_ack_i = 1; tick(); irq_ack_i = 0;
        check("irq_down_ack", 32'(irq_o), 0);
        check("busy_service", 32'(busy_o), 1);
        irq_ack_i = 1; tick(); irq_ack_i = 0;
        check("no_nest", 32'(irq_o), 0);
        irq_ret_i = 1; irq_req_i = next_req; tick(); irq_ret_i = 0;
        check("ret_pulse", 32'(irq_ret_o), (rq.size() > 0) ? 32'(rq.pop_front()) : 32'hdead_beef);
        tick();
        check("ret_clear", 32'(irq_ret_o), 0);
        if (next_req == '0) check("idle_after", 32'(busy_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        check("rst_irq", 32'(irq_o), 0);
        check("rst_cause", irq_cause_o, 0);
        check("rst_ret", 32'(irq_ret_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        rst = 0; tick();
        // single request
        irq_req_i = 16'h0001; expect_grant(16'h0001); tick();
        check("single_next", 32'(irq_o), 1);
        check("single_cause", irq_cause_o, 32'h8000_0010);
        serve('0);
        // simultaneous requests
        irq_req_i = 16'h0005;
        expect_grant(16'h0005); expect_grant(16'h0005); expect_grant(16'h0005);
        serve(16'h0005); serve(16'h0005); serve('0);
        // withdrawal in OFFER
        irq_req_i = 16'h0008; tick();
        check("wd_offer", 32'(irq_o), 1);
        check("wd_cause", irq_cause_o, 32'h8000_0013);
        irq_req_i = '0; tick();
        check("wd_irq", 32'(irq_o), 0);
        check("wd_ret", 32'(irq_ret_o), 0);
        check("wd_busy", 32'(busy_o), 0);
        check("wd_cause_keep", irq_cause_o, 32'h8000_0013);
        irq_ack_i = 1; tick(); irq_ack_i = 0; tick();
        check("late_ack_irq", 32'(irq_o), 0);
        check("late_ack_busy", 32'(busy_o), 0);
        // masking and spurious return
        irq_req_i = 16'h0002; irq_mask_i = 16'hFFFD; tick(); tick(); tick();
        check("mask_irq", 32'(irq_o), 0);
        check("mask_busy", 32'(busy_o), 0);
        irq_ret_i = 1; tick(); irq_ret_i = 0;
        check("spur_ret", 32'(irq_ret_o), 0);
        // reset mid-service
        irq_mask_i = '1; tick();
        check("rs_offer", 32'(irq_o), 1);
        check("rs_cause", irq_cause_o, 32'h8000_0011);
        irq_ack_i = 1; tick(); irq_ack_i = 0;
        check("rs_service", 32'(busy_o), 1);
        rst = 1; tick(); rst = 0; mp = 0;
        check("rs_irq", 32'(irq_o), 0);
        check("rs_cause0", irq_cause_o, 0);
        check("rs_busy", 32'(busy_o), 0);
        irq_ret_i = 1; tick(); irq_ret_i = 0;
        check("rs_no_ret", 32'(irq_ret_o), 0);
        check("rs_reoffer", 32'(irq_o), 1);
        expect_grant(16'h0002);
        serve('0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
